memory_access_hs: RTL and testbench

Next-generation memory-access pipeline stage for etcpu. It sits between execute and writeback and talks to main memory over a request/response handshake with variable latency, stalling execute while a transaction is outstanding. Sub-word loads and stores are steered to the correct byte lane, and loads are sign- or zero-extended. Writeback outputs are registered. Misaligned, out-of-bounds and timed-out accesses raise exceptions.

---
 rtl/utils_top.sv | 22 ++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/memory_access_hs.sv | 194 +++++++++++++++++++
 tb/tb_memory_access_hs.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_top.sv
// Shared etcpu constants and types used by the memory-access stage.
package utils_top;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] BUBBLE    = 32'h0000_0013;

    localparam int UNSIGNED_F3_BIT = 2;

    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for sub-word stores and extraction/extension for loads.
module lsu_lane_align
    import utils_top::*;
(
    input  size_e       size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_dat_i,
    input  logic [31:0] rd_dat_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_dat_o,
    output logic [31:0] ld_dat_o,
    output logic        mis_o
);
    logic [3:0]  mask;
    logic [4:0]  sh_amt;
    logic [31:0] rd_sh;

    always_comb begin
        sh_amt   = {off_i, 3'b000};
        rd_sh    = rd_dat_i >> sh_amt;
        st_dat_o = st_dat_i << sh_amt;
        case (size_i)
            SZ_BYTE: begin
                mask     = 4'b0001;
                mis_o    = 1'b0;
                ld_dat_o = {{24{rd_sh[7] & ~uns_i}}, rd_sh[7:0]};
            end
            SZ_HALF: begin
                mask     = 4'b0011;
                mis_o    = off_i[0];
                ld_dat_o = {{16{rd_sh[15] & ~uns_i}}, rd_sh[15:0]};
            end
            default: begin
                mask     = 4'b1111;
                mis_o    = (off_i != 2'b00);
                ld_dat_o = rd_sh;
            end
        endcase
        be_o = mask << off_i;
    end
endmodule

// File: rtl/memory_access_hs.sv
// Memory-access stage: issues one handshake transaction per load/store, stalls
// execute while it is outstanding, and registers results into writeback.
module memory_access_hs
    import utils_top::*;
#(
    parameter int MAIN_MEM_BYTE_ADD_W = 8,
    parameter int TIMEOUT_CYC         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_vld,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_dat,
    input  logic [31:0] ex_rd2,
    output logic        ex_stall,
    output logic        wb_vld,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_dat,
    output logic        id_fwd_we,
    output logic [4:0]  id_fwd_dst,
    output logic [31:0] id_fwd_dat,
    output logic        exc_main_addr_mis,
    output logic        exc_main_addr_oob,
    output logic        exc_main_timeout,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_dat_in,
    input  logic        mem_rsp_vld,
    input  logic [31:0] mem_dat_out
);
    localparam int               CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic             TO_EN   = (TIMEOUT_CYC != 0);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pc_q, inst_q, dat_q;
    logic [1:0]       off_q;
    size_e            size_q;
    logic             uns_q, ld_q;

    logic        wb_vld_q, mis_q, oob_q, to_q;
    logic [31:0] wb_pc_q, wb_inst_q, wb_dat_q;
    logic        req_q, wen_q;
    logic [31:0] addr_q, wdat_q;
    logic [3:0]  be_q;

    logic [6:0]  ex_op;
    logic        ex_mem, ex_jmp, ex_oob;
    size_e       ex_size;
    logic        busy;

    size_e       lane_size;
    logic        lane_uns;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_st, lane_ld;
    logic        lane_mis;
    logic        expired;

    assign ex_op   = ex_inst[6:0];
    assign ex_mem  = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
    assign ex_jmp  = (ex_op == OP_JAL) || (ex_op == OP_JALR);
    assign ex_size = f3_size(ex_inst[14:12]);
    assign ex_oob  = |(ex_dat >> MAIN_MEM_BYTE_ADD_W);
    assign busy    = (state_q == BUSY);
    assign expired = TO_EN && (cnt_q == CNT_MAX);

    // One lane aligner serves both phases: issue checks/steering in IDLE,
    // load extraction from the captured request while BUSY.
    assign lane_size = busy ? size_q : ex_size;
    assign lane_uns  = busy ? uns_q  : ex_inst[12 + UNSIGNED_F3_BIT];
    assign lane_off  = busy ? off_q  : ex_dat[1:0];

    lsu_lane_align u_align (
        .size_i   (lane_size),
        .uns_i    (lane_uns),
        .off_i    (lane_off),
        .st_dat_i (ex_rd2),
        .rd_dat_i (mem_dat_out),
        .be_o     (lane_be),
        .st_dat_o (lane_st),
        .ld_dat_o (lane_ld),
        .mis_o    (lane_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            inst_q    <= BUBBLE;
            dat_q     <= '0;
            off_q     <= '0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            ld_q      <= 1'b0;
            wb_vld_q  <= 1'b0;
            wb_pc_q   <= '0;
            wb_inst_q <= BUBBLE;
            wb_dat_q  <= '0;
            mis_q     <= 1'b0;
            oob_q     <= 1'b0;
            to_q      <= 1'b0;
            req_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdat_q    <= '0;
        end else begin
            wb_vld_q <= 1'b0;
            mis_q    <= 1'b0;
            oob_q    <= 1'b0;
            to_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_vld) begin
                        if (!ex_mem) begin
                            wb_vld_q  <= 1'b1;
                            wb_pc_q   <= ex_pc;
                            wb_inst_q <= ex_inst;
                            wb_dat_q  <= ex_jmp ? ex_pc + 32'd4 : ex_dat;
                        end else if (lane_mis || ex_oob) begin
                            wb_vld_q  <= 1'b1;
                            wb_pc_q   <= ex_pc;
                            wb_inst_q <= BUBBLE;
                            wb_dat_q  <= '0;
                            mis_q     <= lane_mis;
                            oob_q     <= ex_oob;
                        end else begin
                            pc_q    <= ex_pc;
                            inst_q  <= ex_inst;
                            dat_q   <= ex_dat;
                            off_q   <= ex_dat[1:0];
                            size_q  <= ex_size;
                            uns_q   <= ex_inst[12 + UNSIGNED_F3_BIT];
                            ld_q    <= (ex_op == OP_LOAD);
                            req_q   <= 1'b1;
                            wen_q   <= (ex_op == OP_STORE);
                            addr_q  <= {ex_dat[31:2], 2'b00};
                            be_q    <= lane_be;
                            wdat_q  <= lane_st;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A response in the expiring cycle still completes normally.
                    if (mem_rsp_vld || expired) begin
                        wb_vld_q  <= 1'b1;
                        wb_pc_q   <= pc_q;
                        wb_inst_q <= mem_rsp_vld ? inst_q : BUBBLE;
                        wb_dat_q  <= !mem_rsp_vld ? '0 : (ld_q ? lane_ld : dat_q);
                        to_q      <= !mem_rsp_vld;
                        req_q     <= 1'b0;
                        wen_q     <= 1'b0;
                        addr_q    <= '0;
                        be_q      <= '0;
                        wdat_q    <= '0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_stall          = busy;
    assign wb_vld            = wb_vld_q;
    assign wb_pc             = wb_pc_q;
    assign wb_inst           = wb_inst_q;
    assign wb_dat            = wb_dat_q;
    assign exc_main_addr_mis = mis_q;
    assign exc_main_addr_oob = oob_q;
    assign exc_main_timeout  = to_q;
    assign mem_req           = req_q;
    assign mem_wen           = wen_q;
    assign mem_addr          = addr_q;
    assign mem_be            = be_q;
    assign mem_dat_in        = wdat_q;

    assign id_fwd_we  = wb_vld_q && (wb_inst_q[6:0] != OP_STORE) &&
                        (wb_inst_q[6:0] != OP_BRANCH) && (wb_inst_q[11:7] != 5'd0);
    assign id_fwd_dst = wb_inst_q[11:7];
    assign id_fwd_dat = wb_dat_q;
endmodule

// File: tb/tb_memory_access_hs.sv
// Randomized bench for memory_access_hs against a transaction-level model.
module tb_memory_access_hs;
    localparam int          AW   = 8;
    localparam int          TO   = 4;
    localparam logic [6:0]  OPL  = 7'b0000011;
    localparam logic [6:0]  OPS  = 7'b0100011;
    localparam logic [6:0]  OPB  = 7'b1100011;
    localparam logic [6:0]  OPJ  = 7'b1101111;
    localparam logic [6:0]  OPJR = 7'b1100111;
    localparam logic [6:0]  OPI  = 7'b0010011;
    localparam logic [31:0] BUB  = 32'h0000_0013;

    logic        clk, rst;
    logic        ex_vld;
    logic [31:0] ex_pc, ex_inst, ex_dat, ex_rd2;
    logic        ex_stall, wb_vld;
    logic [31:0] wb_pc, wb_inst, wb_dat;
    logic        id_fwd_we;
    logic [4:0]  id_fwd_dst;
    logic [31:0] id_fwd_dat;
    logic        exc_main_addr_mis, exc_main_addr_oob, exc_main_timeout;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_dat_in, mem_dat_out;
    logic [3:0]  mem_be;
    logic        mem_rsp_vld;

    int n_chk = 0;
    int n_err = 0;

    memory_access_hs #(.MAIN_MEM_BYTE_ADD_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_dat(ex_dat), .ex_rd2(ex_rd2),
        .ex_stall(ex_stall),
        .wb_vld(wb_vld), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_dat(wb_dat),
        .id_fwd_we(id_fwd_we), .id_fwd_dst(id_fwd_dst), .id_fwd_dat(id_fwd_dat),
        .exc_main_addr_mis(exc_main_addr_mis), .exc_main_addr_oob(exc_main_addr_oob),
        .exc_main_timeout(exc_main_timeout),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_dat_in(mem_dat_in), .mem_rsp_vld(mem_rsp_vld), .mem_dat_out(mem_dat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        r[14:12] = f3;
        r[11:7]  = rd;
        r[6:0]   = op;
        return r;
    endfunction

    task automatic chk_wb(input string t, input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] dat, input logic mis, input logic oob, input logic tmo);
        logic we;
        we = vld && (inst[6:0] != OPS) && (inst[6:0] != OPB) && (inst[11:7] != 5'd0);
        check({t, ".vld"}, 32'(wb_vld), 32'(vld));
        check({t, ".fwe"}, 32'(id_fwd_we), 32'(we));
        check({t, ".mis"}, 32'(exc_main_addr_mis), 32'(mis));
        check({t, ".oob"}, 32'(exc_main_addr_oob), 32'(oob));
        check({t, ".tmo"}, 32'(exc_main_timeout), 32'(tmo));
        if (vld) begin
            check({t, ".inst"}, wb_inst, inst);
            check({t, ".fdst"}, 32'(id_fwd_dst), 32'(inst[11:7]));
            if (inst != BUB) begin
                check({t, ".pc"}, wb_pc, pc);
                check({t, ".dat"}, wb_dat, dat);
                check({t, ".fdat"}, id_fwd_dat, dat);
            end
        end
    endtask

    // d = busy cycles without response before the response cycle; d >= TO times out.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] dat,
                         input logic [31:0] rd2, input int d, input logic [31:0] rdata);
        logic [6:0]  op;
        logic [2:0]  f3;
        int          nb, off;
        logic        mem, mis, oob;
        logic [31:0] exp, v;
        op  = inst[6:0];
        f3  = inst[14:12];
        mem = (op == OPL) || (op == OPS);
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(dat[1:0]);
        mis = (off % nb) != 0;
        oob = dat >= (32'd1 << AW);
        ex_vld = 1'b1; ex_inst = inst; ex_pc = pc; ex_dat = dat; ex_rd2 = rd2;
        tick;
        if (!mem) begin
            ex_vld = 1'b0;
            exp = (op == OPJ || op == OPJR) ? pc + 32'd4 : dat;
            chk_wb("alu", 1'b1, pc, inst, exp, 1'b0, 1'b0, 1'b0);
            check("alu.stall", 32'(ex_stall), 32'd0);
            return;
        end
        if (mis || oob) begin
            ex_vld = 1'b0;
            chk_wb("exc", 1'b1, pc, BUB, 32'd0, mis, oob, 1'b0);
            check("exc.req", 32'(mem_req), 32'd0);
            tick;
            chk_wb("exc.after", 1'b0, pc, BUB, 32'd0, 1'b0, 1'b0, 1'b0);
            check("exc.req2", 32'(mem_req), 32'd0);
            return;
        end
        check("req", 32'(mem_req), 32'd1);
        check("wen", 32'(mem_wen), 32'(op == OPS));
        check("addr", mem_addr, dat & ~32'd3);
        check("be", 32'(mem_be), 32'(((1 << nb) - 1) << off));
        if (op == OPS) check("wdat", mem_dat_in, rd2 << (8 * off));
        check("stall", 32'(ex_stall), 32'd1);
        if (op == OPL) begin
            v = rdata >> (8 * off);
            if (nb == 1) v = (!f3[2] && v[7]) ? (v | 32'hFFFF_FF00) : (v & 32'hFF);
            else if (nb == 2) v = (!f3[2] && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'hFFFF);
            exp = v;
        end else begin
            exp = dat;
        end
        for (int j = 1; j <= TO; j++) begin
            if (j == d + 1) begin
                mem_rsp_vld = 1'b1; mem_dat_out = rdata;
                tick;
                mem_rsp_vld = 1'b0; ex_vld = 1'b0;
                chk_wb("done", 1'b1, pc, inst, exp, 1'b0, 1'b0, 1'b0);
                check("done.stall", 32'(ex_stall), 32'd0);
                check("done.req", 32'(mem_req), 32'd0);
                return;
            end
            mem_dat_out = $urandom;
            tick;
            if (j < TO) begin
                check("busy.req", 32'(mem_req), 32'd1);
                check("busy.addr", mem_addr, dat & ~32'd3);
                check("busy.stall", 32'(ex_stall), 32'd1);
                check("busy.vld", 32'(wb_vld), 32'd0);
            end else begin
                ex_vld = 1'b0;
                chk_wb("tmo", 1'b1, pc, BUB, 32'd0, 1'b0, 1'b0, 1'b1);
                check("tmo.req", 32'(mem_req), 32'd0);
                check("tmo.stall", 32'(ex_stall), 32'd0);
                mem_rsp_vld = 1'b1;
                tick;
                mem_rsp_vld = 1'b0;
                chk_wb("late", 1'b0, pc, BUB, 32'd0, 1'b0, 1'b0, 1'b0);
                check("late.stall", 32'(ex_stall), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a, pc;
        int          k, nb;
        rst = 1'b1; ex_vld = 1'b0; ex_pc = '0; ex_inst = '0; ex_dat = '0; ex_rd2 = '0;
        mem_rsp_vld = 1'b0; mem_dat_out = '0;
        tick; tick;
        check("rst.vld", 32'(wb_vld), 32'd0);
        check("rst.inst", wb_inst, BUB);
        check("rst.pc", wb_pc, 32'd0);
        check("rst.dat", wb_dat, 32'd0);
        check("rst.req", 32'(mem_req), 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.be", 32'(mem_be), 32'd0);
        check("rst.stall", 32'(ex_stall), 32'd0);
        check("rst.fwe", 32'(id_fwd_we), 32'd0);
        check("rst.fdat", id_fwd_dat, 32'd0);
        rst = 1'b0;

        issue(mk(OPS, 3'd2, 5'd3), 32'h100, 32'h10, 32'hAABBCCDD, 3, 32'h0);
        issue(mk(OPS, 3'd0, 5'd4), 32'h104, 32'h13, 32'h000000EE, 0, 32'h0);
        issue(mk(OPL, 3'd0, 5'd5), 32'h108, 32'h12, 32'h0, 1, 32'h0080FF00);
        issue(mk(OPL, 3'd4, 5'd6), 32'h10C, 32'h12, 32'h0, 0, 32'h0080FF00);
        issue(mk(OPL, 3'd1, 5'd7), 32'h110, 32'h02, 32'h0, 2, 32'h80010000);
        issue(mk(OPL, 3'd2, 5'd8), 32'h114, 32'h06, 32'h0, 0, 32'h0);
        issue(mk(OPL, 3'd2, 5'd8), 32'h118, 32'h100, 32'h0, 0, 32'h0);
        issue(mk(OPL, 3'd2, 5'd8), 32'h11C, 32'h101, 32'h0, 0, 32'h0);
        issue(mk(OPL, 3'd2, 5'd9), 32'h120, 32'h20, 32'h0, 5, 32'h12345678);

        // Reset while a load is outstanding; its later response must vanish.
        ex_vld = 1'b1; ex_inst = mk(OPL, 3'd2, 5'd10); ex_dat = 32'h24; ex_pc = 32'h124;
        tick;
        ex_vld = 1'b0;
        check("rstb.req", 32'(mem_req), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstb.req0", 32'(mem_req), 32'd0);
        check("rstb.stall", 32'(ex_stall), 32'd0);
        check("rstb.inst", wb_inst, BUB);
        mem_rsp_vld = 1'b1; mem_dat_out = 32'hDEADBEEF;
        tick;
        mem_rsp_vld = 1'b0;
        check("rstb.late", 32'(wb_vld), 32'd0);
        check("rstb.stall2", 32'(ex_stall), 32'd0);

        pc = 32'h200;
        for (int i = 0; i < 8; i++) begin
            issue(mk(OPI, 3'd0, 5'(i + 1)), pc, $urandom, $urandom, 0, 32'h0);
            pc += 4;
        end
        issue(mk(OPJ, 3'd0, 5'd1), pc, $urandom, 32'h0, 0, 32'h0);
        issue(mk(OPJR, 3'd0, 5'd2), pc + 4, $urandom, 32'h0, 0, 32'h0);
        issue(mk(OPB, 3'd1, 5'd3), pc + 8, $urandom, 32'h0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 9);
            pc = $urandom & ~32'd3;
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            case (k)
                0, 1, 2: issue(mk(OPI, 3'($urandom), 5'($urandom)), pc, $urandom, $urandom, 0, 32'h0);
                3:       issue(mk(($urandom_range(0, 1) == 1) ? OPJ : OPJR, 3'd0, 5'($urandom)), pc, $urandom, 32'h0, 0, 32'h0);
                4:       issue(mk(OPB, 3'($urandom), 5'($urandom)), pc, $urandom, 32'h0, 0, 32'h0);
                5, 6, 7: begin
                    nb = $urandom_range(0, 4);
                    issue(mk(OPL, (nb == 3) ? 3'd4 : (nb == 4) ? 3'd5 : 3'(nb), 5'($urandom)),
                          pc, a, $urandom, $urandom_range(0, 5), $urandom);
                end
                8:       issue(mk(OPS, 3'($urandom_range(0, 2)), 5'($urandom)), pc, a, $urandom,
                               $urandom_range(0, 5), 32'h0);
                default: begin
                    ex_vld = 1'b0;
                    tick;
                    chk_wb("idle", 1'b0, pc, BUB, 32'd0, 1'b0, 1'b0, 1'b0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
